// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared quadrature constants, state encoding and phase mapping
//
// Purpose: definitions shared by the quadrature generator and decoder.
// Contents:
//    STATES  - quarter-counts per revolution at the default CPR
//    MAX14   - largest 14-bit position
//    HALF14  - half-turn distance; ties at this distance go CW
//    IDLE/MOVE - generator state encoding
//    phase_ab  - pos[1:0] -> {A,B} before inversion (Gray sequence)
package quad_pkg;

   localparam int unsigned CPR_DEFAULT = 4096;
   localparam int unsigned STATES      = 4 * CPR_DEFAULT;
   localparam logic [13:0] MAX14       = 14'd16383;
   localparam logic [13:0] HALF14      = 14'd8192;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] MOVE = 1'b1;

   // 0->00, 1->01, 2->11, 3->10: adjacent positions differ in exactly one bit
   function automatic logic [1:0] phase_ab(input logic [1:0] p);
      return {p[1], p[1] ^ p[0]};
   endfunction

endpackage

// File: rtl/quad_gen_12bit.sv
// rtl/quad_gen_12bit.sv - quadrature A/B/Z generator driven to a 14-bit target
//
// Purpose: accepts a target position in quarter-counts, takes the shortest path
// to it one quarter-count at a time every P clocks, and emits the matching
// quadrature A/B phases plus an index pulse near position 0.
// Ports:
//    clk, rst                  - single clock, asynchronous active-high reset
//    target14/valid/ready      - target handshake (ready only in IDLE, no zero_req)
//    step_period               - clocks between steps, clamped to >= 2 at accept
//    stop                      - abort the current move
//    zero_req                  - in IDLE, clear pos14[13:2] keeping the A/B phase
//    a_out, b_out, z_out       - registered quadrature and index outputs
//    pos14, busy, step_pulse, dir - position and move status
module quad_gen_12bit
   import quad_pkg::*;
#(
   parameter int   CPR      = 4096,
   parameter logic INVERT_A = 1'b0,
   parameter logic INVERT_B = 1'b0,
   parameter logic INDEX_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [13:0] target14,
   input  logic        target_valid,
   output logic        target_ready,
   input  logic [7:0]  step_period,
   input  logic        stop,
   input  logic        zero_req,
   output logic        a_out,
   output logic        b_out,
   output logic        z_out,
   output logic [13:0] pos14,
   output logic        busy,
   output logic        step_pulse,
   output logic        dir
);

   // Wrap point of the position counter; 16383 at the default CPR.
   localparam logic [13:0] MAX_POS = 14'(4 * CPR - 1);

   logic [0:0]  state_q,  state_d;
   logic [13:0] pos_q,    pos_d;
   logic [13:0] target_q, target_d;
   logic [7:0]  period_q, period_d;
   logic [7:0]  timer_q,  timer_d;
   logic        dir_q,    dir_d;
   logic        busy_q,   busy_d;
   logic        step_q,   step_d;
   logic        a_q, b_q, z_q;
   logic [13:0] delta;
   logic [1:0]  ab_d;
   logic        z_d;

   assign target_ready = (state_q == IDLE) && !zero_req;

   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      target_d = target_q;
      period_d = period_q;
      timer_d  = timer_q;
      dir_d    = dir_q;
      step_d   = 1'b0;
      delta    = target14 - pos_q;

      if (state_q == IDLE) begin
         if (zero_req) begin
            pos_d = {12'd0, pos_q[1:0]};
         end else if (target_valid) begin
            target_d = target14;
            period_d = (step_period < 8'd2) ? 8'd2 : step_period;
            dir_d    = (delta != 14'd0) && (delta <= HALF14);
            timer_d  = 8'd0;
            if (delta != 14'd0) begin
               state_d = MOVE;
            end
         end
      end else begin
         // Timer counts 0..P-1 after acceptance, so the step lands P edges later.
         if (timer_q == period_q - 8'd1) begin
            timer_d = 8'd0;
            step_d  = 1'b1;
            if (dir_q) begin
               pos_d = (pos_q == MAX_POS) ? 14'd0 : pos_q + 14'd1;
            end else begin
               pos_d = (pos_q == 14'd0) ? MAX_POS : pos_q - 14'd1;
            end
            if (pos_d == target_q) begin
               state_d = IDLE;
            end
         end else begin
            timer_d = timer_q + 8'd1;
         end
         // A step on the same edge as stop is still emitted above.
         if (stop) begin
            state_d = IDLE;
            timer_d = 8'd0;
         end
      end

      busy_d = (state_d == MOVE);
      ab_d   = phase_ab(pos_d[1:0]);
      z_d    = INDEX_EN && (pos_d[13:2] == 12'd0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         pos_q    <= 14'd0;
         target_q <= 14'd0;
         period_q <= 8'd2;
         timer_q  <= 8'd0;
         dir_q    <= 1'b0;
         busy_q   <= 1'b0;
         step_q   <= 1'b0;
         a_q      <= INVERT_A;
         b_q      <= INVERT_B;
         z_q      <= INDEX_EN;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         target_q <= target_d;
         period_q <= period_d;
         timer_q  <= timer_d;
         dir_q    <= dir_d;
         busy_q   <= busy_d;
         step_q   <= step_d;
         a_q      <= ab_d[1] ^ INVERT_A;
         b_q      <= ab_d[0] ^ INVERT_B;
         z_q      <= z_d;
      end
   end

   assign pos14      = pos_q;
   assign busy       = busy_q;
   assign step_pulse = step_q;
   assign dir        = dir_q;
   assign a_out      = a_q;
   assign b_out      = b_q;
   assign z_out      = z_q;

endmodule

// File: tb/tb_quad_gen_12bit.sv
// tb/tb_quad_gen_12bit.sv - self-checking bench for quad_gen_12bit
module tb_quad_gen_12bit;

   logic        clk = 1'b0;
   logic        rst;
   logic [13:0] target14;
   logic        target_valid;
   logic        target_ready;
   logic [7:0]  step_period;
   logic        stop;
   logic        zero_req;
   logic        a_out, b_out, z_out;
   logic [13:0] pos14;
   logic        busy, step_pulse, dir;

   quad_gen_12bit dut (
      .clk          (clk),
      .rst          (rst),
      .target14     (target14),
      .target_valid (target_valid),
      .target_ready (target_ready),
      .step_period  (step_period),
      .stop         (stop),
      .zero_req     (zero_req),
      .a_out        (a_out),
      .b_out        (b_out),
      .z_out        (z_out),
      .pos14        (pos14),
      .busy         (busy),
      .step_pulse   (step_pulse),
      .dir          (dir)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference state: expected position and an independent A/B decoder.
   int         m_pos;
   int         dec_pos;
   logic [1:0] prev_ab;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] exp_ab(input int p);
      logic [1:0] tbl [4];
      tbl[0] = 2'b00; tbl[1] = 2'b01; tbl[2] = 2'b11; tbl[3] = 2'b10;
      return tbl[p % 4];
   endfunction

   function automatic int gray_idx(input logic [1:0] ab);
      case (ab)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   // Decode the observed A/B, then compare position, phase, index and decoder.
   task automatic observe();
      logic [1:0] cur;
      int d;
      cur = {a_out, b_out};
      d = (gray_idx(cur) - gray_idx(prev_ab) + 4) % 4;
      if (d == 1) dec_pos = (dec_pos + 1) % 16384;
      if (d == 3) dec_pos = (dec_pos + 16383) % 16384;
      chk("illegal_ab_jump", (d == 2), 0);
      prev_ab = cur;
      chk("pos14", pos14, m_pos);
      chk("ab_phase", cur, exp_ab(m_pos));
      chk("z_out", z_out, (m_pos < 4));
      chk("decoder_pos", dec_pos, m_pos);
   endtask

   // Offer one target and follow the move cycle by cycle. stop_after >= 0 aborts
   // once that many steps have been seen.
   task automatic do_move(input logic [13:0] tgt, input int per, input int stop_after,
                          output int steps);
      int p_eff, delta, total, limit, done;
      bit d, stop_issued, exp_step;
      p_eff = (per < 2) ? 2 : per;
      delta = (int'(tgt) - m_pos + 16384) % 16384;
      total = (delta == 0) ? 0 : ((delta <= 8192) ? delta : 16384 - delta);
      d     = (delta != 0) && (delta <= 8192);
      limit = (stop_after >= 0 && stop_after < total) ? stop_after * p_eff + 3
                                                       : total * p_eff + 3;
      @(negedge clk);
      target14 = tgt; step_period = 8'(per); target_valid = 1'b1;
      #1 chk("target_ready", target_ready, 1);
      @(posedge clk);
      #1 target_valid = 1'b0;
      step_period = 8'($urandom_range(0, 255));
      done = 0; stop_issued = 1'b0;
      for (int c = 0; c <= limit; c++) begin
         @(negedge clk);
         if (c == 1 && total > 1) zero_req = 1'b1;
         if (c == 2) zero_req = 1'b0;
         exp_step = (c > 0) && (c % p_eff == 0) && (done < total) && !stop_issued;
         if (exp_step) begin
            done++;
            m_pos = d ? (m_pos + 1) % 16384 : (m_pos + 16383) % 16384;
         end
         chk("step_pulse", step_pulse, exp_step);
         chk("busy", busy, (done < total) && !stop_issued);
         chk("dir", dir, d);
         observe();
         if (stop_after >= 0 && done == stop_after && done < total && !stop_issued) begin
            stop = 1'b1;
            stop_issued = 1'b1;
            limit = c + 3;
         end
      end
      stop = 1'b0;
      zero_req = 1'b0;
      steps = done;
   endtask

   typedef struct {
      logic [13:0] tgt;
      int          per;
      int          exp_steps;
      logic        exp_dir;
      logic [13:0] exp_final;
   } vec_t;

   initial begin
      vec_t tbl [7];
      int   steps;
      logic [13:0] rtgt;

      tbl[0] = '{14'd5,     4, 5,    1'b1, 14'd5};
      tbl[1] = '{14'd2,     3, 3,    1'b0, 14'd2};
      tbl[2] = '{14'd16380, 1, 6,    1'b0, 14'd16380};
      tbl[3] = '{14'd16380, 5, 0,    1'b0, 14'd16380};
      tbl[4] = '{14'd4,     2, 8,    1'b1, 14'd4};
      tbl[5] = '{14'd0,     3, 4,    1'b0, 14'd0};
      tbl[6] = '{14'd8192,  0, 8192, 1'b1, 14'd8192};

      rst = 1'b1; target14 = '0; target_valid = 1'b0; step_period = 8'd4;
      stop = 1'b0; zero_req = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_pos14", pos14, 0);
      chk("rst_busy", busy, 0);
      chk("rst_step", step_pulse, 0);
      chk("rst_dir", dir, 0);
      chk("rst_ab", {a_out, b_out}, 2'b00);
      chk("rst_z", z_out, 1);
      chk("rst_ready", target_ready, 1);
      rst = 1'b0;
      m_pos = 0; dec_pos = 0; prev_ab = {a_out, b_out};

      for (int i = 0; i < 7; i++) begin
         do_move(tbl[i].tgt, tbl[i].per, -1, steps);
         chk($sformatf("tbl%0d_steps", i), steps, tbl[i].exp_steps);
         chk($sformatf("tbl%0d_dir", i), dir, tbl[i].exp_dir);
         chk($sformatf("tbl%0d_final", i), pos14, tbl[i].exp_final);
      end

      // Reset in the middle of a move.
      @(negedge clk);
      target14 = 14'd8300; step_period = 8'd2; target_valid = 1'b1;
      @(posedge clk);
      #1 target_valid = 1'b0;
      repeat (9) @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("midrst_pos14", pos14, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_step", step_pulse, 0);
      chk("midrst_dir", dir, 0);
      chk("midrst_ab", {a_out, b_out}, 2'b00);
      chk("midrst_z", z_out, 1);
      @(negedge clk);
      rst = 1'b0;
      m_pos = 0; dec_pos = 0; prev_ab = {a_out, b_out};
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("postrst_step", step_pulse, 0);
         chk("postrst_busy", busy, 0);
         observe();
      end

      // Stop after 3 steps of a 10-step move.
      do_move(14'd10, 3, 3, steps);
      chk("stop_steps", steps, 3);
      chk("stop_pos14", pos14, 3);
      chk("stop_busy", busy, 0);

      // zero_req with target_valid: zero wins, target ignored.
      @(negedge clk);
      zero_req = 1'b1; target_valid = 1'b1; target14 = 14'd50; step_period = 8'd2;
      #1 chk("zero_ready", target_ready, 0);
      @(posedge clk);
      #1 zero_req = 1'b0; target_valid = 1'b0;
      m_pos = m_pos % 4; dec_pos = dec_pos % 4;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("zero_busy", busy, 0);
         chk("zero_step", step_pulse, 0);
         observe();
      end
      chk("zero_pos14", pos14, 3);
      chk("zero_z", z_out, 1);

      // Random short moves around the current position, decoder in loopback.
      for (int i = 0; i < 20; i++) begin
         rtgt = 14'((m_pos + int'($urandom_range(0, 80)) - 40 + 16384) % 16384);
         do_move(rtgt, int'($urandom_range(0, 6)), -1, steps);
         chk("rand_final", pos14, rtgt);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/quad_gen_12bit.md
QUAD_GEN_12BIT -- requirements
Module: quad_gen_12bit

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- CPR, 4096, encoder counts per revolution.
- INVERT_A, 1'b0, XOR applied to a_out.
- INVERT_B, 1'b0, XOR applied to b_out.
- INDEX_EN, 1'b1, enables z_out.

REQ-002 Ports SHALL be (name, direction, width, meaning), clock and reset first:
- clk, in, 1, single clock.
- rst, in, 1, asynchronous active-high reset.
- target14, in, 14, requested position in quarter-counts.
- target_valid, in, 1, target offered.
- target_ready, out, 1, target accepted when valid and ready are both high.
- step_period, in, 8, clk cycles between emitted edges.
- stop, in, 1, abort the current move.
- zero_req, in, 1, redefine the current position as 0.
- a_out, out, 1, quadrature A.
- b_out, out, 1, quadrature B.
- z_out, out, 1, index.
- pos14, out, 14, current emitted position.
- busy, out, 1, move in progress.
- step_pulse, out, 1, one-cycle pulse per emitted edge.
- dir, out, 1, 1 = CW.

REQ-003 The design SHALL use one clock; reset is asynchronous and active-high.

Function
REQ-004 The state machine SHALL have two states: IDLE and MOVE.
REQ-005 target_ready SHALL be combinational and equal (state==IDLE) && !zero_req.
REQ-006 On acceptance, the block SHALL latch target14 and latch P = max(step_period, 2).
REQ-007 On acceptance, the block SHALL compute delta = (target14 - pos14) mod 16384; delta==0 keeps IDLE with no step.
REQ-008 Direction SHALL be CW (dir=1) for delta in 1..8192 and ACW otherwise; the 8192 tie goes CW.
REQ-009 On entering MOVE, busy SHALL be 1 and the step timer SHALL be cleared.
REQ-010 Steps SHALL be paced as follows:
- acceptance at edge k gives the first step at edge k+P;
- later steps occur every P cycles.
REQ-011 Each step SHALL do all of the following on the same edge:
- pos14 +1 for CW, wrapping 16383 to 0;
- pos14 -1 for ACW, wrapping 0 to 16383;
- step_pulse=1 for exactly one cycle;
- a_out and b_out updated.
REQ-012 The phase mapping from pos14[1:0] to {A,B} before inversion SHALL be 0→00, 1→01, 2→11, 3→10, so that CW produces 00→01→11→10→00.
REQ-013 Consecutive emitted edges SHALL change exactly one of A or B; a two-bit change is forbidden in all cases.
REQ-014 When the stepped pos14 equals the latched target, the next state SHALL be IDLE and busy SHALL be 0 from the following cycle.
REQ-015 stop in MOVE SHALL force IDLE on the next edge; a step coinciding with stop is still emitted, and A/B hold thereafter.
REQ-016 zero_req in IDLE SHALL set pos14 to {12'd0, pos14[1:0]}, preserving the A/B phase.
REQ-017 zero_req in MOVE SHALL be ignored.
REQ-018 zero_req asserted together with target_valid SHALL be handled as zero wins and the target is not accepted.
REQ-019 z_out SHALL be INDEX_EN && (pos14[13:2]==0), registered with pos14.
REQ-020 dir SHALL be updated at acceptance and held until the next acceptance.
REQ-021 step_period changes during MOVE SHALL have no effect.
REQ-022 a_out, b_out and z_out SHALL be driven directly from flops.

Reset
REQ-023 On rst the block SHALL reset to: state IDLE, pos14=0, busy=0, step_pulse=0, dir=0, a_out=INVERT_A, b_out=INVERT_B, z_out=INDEX_EN, timer=0.
REQ-024 rst asserted mid-MOVE SHALL abandon the move immediately with no further steps after deassertion.

Structure
REQ-025 A shared package quad_pkg SHALL hold STATES (4*CPR), MAX14 (16383), HALF14 (8192), the IDLE/MOVE state encoding and the pos→{A,B} phase function, shared with the decoder.
REQ-026 The block SHALL have no sub-module; the timer, FSM and position counter live in quad_gen_12bit.

Verification
REQ-027 Basic CW move: pos 0, target 5, period 4 → five step_pulses 4 cycles apart, {A,B} sequence 01,11,10,00,01, final pos14=5, busy falls.
REQ-028 Wrap and shortest path: pos 2, target 16380 → six ACW steps, pos passes 0 to 16383 and ends at 16380, z_out=1 while pos14 in 0..3.
REQ-029 Tie and clamp: pos 0, target 8192, step_period 0 → CW with period 2, exactly 8192 steps.
REQ-030 Stop and zero: stop after 3 steps of a 10-step move → pos14=3 and IDLE; then zero_req → pos14=3 (phase kept), z_out=1.
REQ-031 Loopback: output looped through the decoder with MIN_STEP_CYCLES=2 and random targets and periods → decoder pos14 tracks generator pos14 and illegal never asserts.
REQ-032 Reset mid-move: rst in the middle of a move → all outputs take their reset values and no step_pulse occurs until a new target is accepted.
